// File: rtl/panel_string_writer.sv
// Text-panel string writer: edits a working line buffer from a valid/ready command
// stream and publishes it to the panel only at frame boundaries. Scroll-on-full via PANEL_WRITER_SCROLL_EN.
//
// state    | meaning
// st_idle  | accepting commands, commits dirty buffer on frame_start
// st_clear | writing fill_char into one slot per cycle, commands stalled
module panel_string_writer #(
   parameter int         char_count = 13,
   parameter logic [7:0] fill_char  = 8'h20,
   parameter int         cur_w      = 4
) (
   input  logic                    vga_clk,
   input  logic                    rst,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [1:0]              wr_cmd,
   input  logic [7:0]              wr_char,
   input  logic                    frame_start,
   output logic [8*char_count-1:0] panel_string,
   output logic [cur_w-1:0]        cursor,
   output logic                    full,
   output logic                    overflow
);
   typedef enum logic {st_idle, st_clear} state_t;

   localparam logic [1:0]       cmd_put   = 2'b00;
   localparam logic [1:0]       cmd_bksp  = 2'b01;
   localparam logic [1:0]       cmd_clear = 2'b10;
   localparam logic [1:0]       cmd_home  = 2'b11;
   localparam logic [cur_w-1:0] cnt_max   = cur_w'(char_count);
   localparam logic [cur_w-1:0] idx_last  = cur_w'(char_count - 1);

   state_t                  state, state_nxt;
   logic [7:0]              slots [char_count];
   logic [8*char_count-1:0] packed_buf;
   logic [cur_w-1:0]        idx;
   logic                    dirty, pending, xfer;

   assign wr_ready = (state == st_idle);
   assign xfer     = wr_valid && (state == st_idle);

   always_ff @(posedge vga_clk) begin
      if (rst) state <= st_idle;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         st_idle:  if (xfer && wr_cmd == cmd_clear) state_nxt = st_clear;
         st_clear: if (idx == idx_last) state_nxt = st_idle;
         default:  state_nxt = st_idle;
      endcase
   end

   always_comb begin
      packed_buf = '0;
      for (int k = 0; k < char_count; k++)
         packed_buf[8*(char_count-k)-1 -: 8] = slots[k];
   end

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         for (int k = 0; k < char_count; k++) slots[k] <= fill_char;
         panel_string <= {char_count{fill_char}};
         cursor       <= '0;
         full         <= 1'b0;
         overflow     <= 1'b0;
         dirty        <= 1'b0;
         pending      <= 1'b0;
         idx          <= '0;
      end else begin
         overflow <= 1'b0;
         if (state == st_idle) begin
            // A frame seen during CLEAR is honoured on the first idle cycle.
            if ((frame_start || pending) && dirty) begin
               panel_string <= packed_buf;
               dirty        <= 1'b0;
            end
            pending <= 1'b0;
            if (xfer) begin
               case (wr_cmd)
                  cmd_put: begin
                     if (cursor != cnt_max) begin
                        slots[cursor] <= wr_char;
                        cursor        <= cursor + 1'b1;
                        full          <= ((cursor + 1'b1) == cnt_max);
                        dirty         <= 1'b1;
                     end else begin
`ifdef PANEL_WRITER_SCROLL_EN
                        for (int k = 0; k < char_count - 1; k++) slots[k] <= slots[k+1];
                        slots[char_count-1] <= wr_char;
                        dirty               <= 1'b1;
`else
                        overflow <= 1'b1;
`endif
                     end
                  end
                  cmd_bksp: begin
                     if (cursor != '0) begin
                        slots[cursor - 1'b1] <= fill_char;
                        cursor               <= cursor - 1'b1;
                        full                 <= 1'b0;
                        dirty                <= 1'b1;
                     end
                  end
                  cmd_clear: idx <= '0;
                  cmd_home: begin
                     cursor <= '0;
                     full   <= 1'b0;
                  end
                  default: ;
               endcase
            end
         end else begin
            pending    <= pending | frame_start;
            slots[idx] <= fill_char;
            idx        <= idx + 1'b1;
            if (idx == idx_last) begin
               cursor <= '0;
               full   <= 1'b0;
               dirty  <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_panel_string_writer.sv
// Randomized and directed bench for panel_string_writer against a transaction-level line model.
module tb_panel_string_writer;
   localparam int         N    = 13;
   localparam logic [7:0] FILL = 8'h20;
`ifdef PANEL_WRITER_SCROLL_EN
   localparam bit scroll = 1'b1;
`else
   localparam bit scroll = 1'b0;
`endif

   logic         vga_clk = 1'b0;
   logic         rst, wr_valid, frame_start;
   logic [1:0]   wr_cmd;
   logic [7:0]   wr_char;
   logic         wr_ready, full, overflow;
   logic [8*N-1:0] panel_string;
   logic [3:0]   cursor;

   int tests = 0;
   int failed = 0;

   logic [7:0] mb   [N];
   logic [7:0] mpub [N];
   int         mc;
   bit         mdirty;

   always #5 vga_clk = ~vga_clk;

   panel_string_writer #(.char_count(N), .fill_char(FILL), .cur_w(4)) dut (
      .vga_clk(vga_clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_cmd(wr_cmd), .wr_char(wr_char), .frame_start(frame_start),
      .panel_string(panel_string), .cursor(cursor), .full(full), .overflow(overflow)
   );

   function automatic logic [8*N-1:0] pub_bus();
      logic [8*N-1:0] v;
      for (int k = 0; k < N; k++) v[8*(N-k)-1 -: 8] = mpub[k];
      return v;
   endfunction

   function automatic logic [8*N-1:0] all_fill();
      logic [8*N-1:0] v;
      for (int k = 0; k < N; k++) v[8*(N-k)-1 -: 8] = FILL;
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin mb[k] = FILL; mpub[k] = FILL; end
      mc = 0;
      mdirty = 0;
   endtask

   task automatic model_frame();
      if (mdirty) begin mpub = mb; mdirty = 0; end
   endtask

   task automatic model_cmd(input logic [1:0] c, input logic [7:0] ch, output bit ovf);
      ovf = 0;
      case (c)
         2'b00: begin
            if (mc < N) begin mb[mc] = ch; mc++; mdirty = 1; end
            else if (scroll) begin
               for (int k = 0; k < N - 1; k++) mb[k] = mb[k+1];
               mb[N-1] = ch;
               mdirty = 1;
            end else ovf = 1;
         end
         2'b01: if (mc > 0) begin mc--; mb[mc] = FILL; mdirty = 1; end
         2'b10: begin
            for (int k = 0; k < N; k++) mb[k] = FILL;
            mc = 0;
            mdirty = 1;
         end
         default: mc = 0;
      endcase
   endtask

   task automatic send(input logic [1:0] c, input logic [7:0] ch, input bit fs, output bit ovf);
      int guard;
      guard = 0;
      @(negedge vga_clk);
      while (!wr_ready && guard < 40) begin @(negedge vga_clk); guard++; end
      if (!wr_ready) begin
         tests++; failed++;
         $display("FAIL ready_timeout wr_ready=%0b required=1", wr_ready);
      end
      wr_valid = 1; wr_cmd = c; wr_char = ch; frame_start = fs;
      @(posedge vga_clk); #1;
      wr_valid = 0; frame_start = 0;
      if (fs) model_frame();
      model_cmd(c, ch, ovf);
   endtask

   task automatic pulse_frame();
      @(negedge vga_clk);
      frame_start = 1;
      @(posedge vga_clk); #1;
      frame_start = 0;
      model_frame();
   endtask

   task automatic wait_ready();
      int g;
      g = 0;
      while (!wr_ready && g < 40) begin @(posedge vga_clk); #1; g++; end
      if (!wr_ready) begin
         tests++; failed++;
         $display("FAIL clear_timeout wr_ready=%0b required=1", wr_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1; wr_valid = 0; frame_start = 0; wr_cmd = 0; wr_char = 0;
      repeat (3) @(posedge vga_clk);
      #1 rst = 0;
      model_reset();
      tests++; if (panel_string !== all_fill()) begin failed++; $display("FAIL reset_string got=%h required=%h", panel_string, all_fill()); end
      tests++; if (cursor !== 4'd0) begin failed++; $display("FAIL reset_cursor got=%0d required=0", cursor); end
      tests++; if (full !== 1'b0) begin failed++; $display("FAIL reset_full got=%0b required=0", full); end
      tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL reset_overflow got=%0b required=0", overflow); end
      tests++; if (wr_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got=%0b required=1", wr_ready); end
   endtask

   task automatic test_hello();
      bit o;
      send(2'b00, 8'h48, 0, o);
      send(2'b00, 8'h49, 0, o);
      pulse_frame();
      tests++; if (panel_string[8*N-1 -: 16] !== 16'h4849) begin failed++; $display("FAIL hello_top got=%h required=4849", panel_string[8*N-1 -: 16]); end
      tests++; if (panel_string !== pub_bus()) begin failed++; $display("FAIL hello_string got=%h required=%h", panel_string, pub_bus()); end
      tests++; if (cursor !== 4'd2) begin failed++; $display("FAIL hello_cursor got=%0d required=2", cursor); end
   endtask

   task automatic test_hold();
      bit o;
      send(2'b00, 8'h41, 0, o);
      repeat (100) @(posedge vga_clk);
      #1;
      tests++; if (panel_string !== pub_bus()) begin failed++; $display("FAIL hold_string got=%h required=%h", panel_string, pub_bus()); end
      pulse_frame();
      tests++; if (panel_string[8*(N-2)-1 -: 8] !== 8'h41) begin failed++; $display("FAIL hold_slot2 got=%h required=41", panel_string[8*(N-2)-1 -: 8]); end
      tests++; if (panel_string !== pub_bus()) begin failed++; $display("FAIL hold_commit got=%h required=%h", panel_string, pub_bus()); end
   endtask

   task automatic test_backspace();
      bit o;
      for (int i = 0; i < 4; i++) begin
         send(2'b01, 8'h00, 0, o);
         tests++; if (cursor !== 4'(mc)) begin failed++; $display("FAIL bksp_cursor step=%0d got=%0d required=%0d", i, cursor, mc); end
      end
      tests++; if (cursor !== 4'd0) begin failed++; $display("FAIL bksp_final got=%0d required=0", cursor); end
      pulse_frame();
      tests++; if (panel_string !== all_fill()) begin failed++; $display("FAIL bksp_string got=%h required=%h", panel_string, all_fill()); end
   endtask

   task automatic test_clear();
      bit o;
      int low;
      send(2'b00, 8'h58, 0, o);
      send(2'b00, 8'h59, 0, o);
      pulse_frame();
      send(2'b10, 8'h00, 0, o);
      low = 0;
      while (!wr_ready && low < 40) begin
         low++;
         if (low == 5) frame_start = 1;
         @(posedge vga_clk); #1;
         frame_start = 0;
      end
      tests++; if (low != 13) begin failed++; $display("FAIL clear_busy_cycles got=%0d required=13", low); end
      @(posedge vga_clk); #1;
      model_frame();
      tests++; if (panel_string !== all_fill()) begin failed++; $display("FAIL clear_pending_commit got=%h required=%h", panel_string, all_fill()); end
      tests++; if (cursor !== 4'd0) begin failed++; $display("FAIL clear_cursor got=%0d required=0", cursor); end
   endtask

   task automatic test_full();
      bit o;
      for (int i = 0; i < N; i++) send(2'b00, 8'h61 + 8'(i), 0, o);
      tests++; if (full !== 1'b1) begin failed++; $display("FAIL full_flag got=%0b required=1", full); end
      tests++; if (cursor !== 4'(N)) begin failed++; $display("FAIL full_cursor got=%0d required=%0d", cursor, N); end
      send(2'b00, 8'h6e, 0, o);
      tests++; if (overflow !== o) begin failed++; $display("FAIL full_overflow got=%0b required=%0b", overflow, o); end
      @(posedge vga_clk); #1;
      tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL overflow_pulse_width got=%0b required=0", overflow); end
      pulse_frame();
      tests++; if (panel_string[8*N-1 -: 8] !== (scroll ? 8'h62 : 8'h61)) begin failed++; $display("FAIL full_slot0 got=%h", panel_string[8*N-1 -: 8]); end
      tests++; if (panel_string !== pub_bus()) begin failed++; $display("FAIL full_string got=%h required=%h", panel_string, pub_bus()); end
   endtask

   task automatic test_same_edge();
      bit o;
      send(2'b11, 8'h00, 0, o);
      send(2'b00, 8'h51, 0, o);
      send(2'b00, 8'h52, 1, o);
      tests++; if (panel_string !== pub_bus()) begin failed++; $display("FAIL same_edge_commit got=%h required=%h", panel_string, pub_bus()); end
      pulse_frame();
      tests++; if (panel_string !== pub_bus()) begin failed++; $display("FAIL same_edge_next got=%h required=%h", panel_string, pub_bus()); end
   endtask

   task automatic test_reset_mid_clear();
      bit o;
      send(2'b00, 8'h7a, 0, o);
      send(2'b10, 8'h00, 0, o);
      @(posedge vga_clk); #1;
      frame_start = 1;
      @(posedge vga_clk); #1;
      frame_start = 0;
      rst = 1;
      @(posedge vga_clk); #1;
      rst = 0;
      model_reset();
      tests++; if (panel_string !== all_fill()) begin failed++; $display("FAIL rst_clear_string got=%h required=%h", panel_string, all_fill()); end
      tests++; if (cursor !== 4'd0) begin failed++; $display("FAIL rst_clear_cursor got=%0d required=0", cursor); end
      tests++; if (wr_ready !== 1'b1) begin failed++; $display("FAIL rst_clear_ready got=%0b required=1", wr_ready); end
      send(2'b00, 8'h71, 0, o);
      repeat (20) @(posedge vga_clk);
      #1;
      tests++; if (panel_string !== pub_bus()) begin failed++; $display("FAIL rst_no_commit got=%h required=%h", panel_string, pub_bus()); end
   endtask

   task automatic test_random();
      bit o;
      logic [1:0] c;
      int r;
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 55) c = 2'b00;
         else if (r < 80) c = 2'b01;
         else if (r < 85) c = 2'b10;
         else if (r < 92) c = 2'b11;
         else begin
            pulse_frame();
            tests++; if (panel_string !== pub_bus()) begin failed++; $display("FAIL rand_frame it=%0d got=%h required=%h", i, panel_string, pub_bus()); end
            continue;
         end
         send(c, 8'($urandom_range(33, 126)), ($urandom_range(0, 4) == 0), o);
         tests++; if (overflow !== o) begin failed++; $display("FAIL rand_overflow it=%0d got=%0b required=%0b", i, overflow, o); end
         if (c == 2'b10) wait_ready();
         tests++; if (cursor !== 4'(mc)) begin failed++; $display("FAIL rand_cursor it=%0d got=%0d required=%0d", i, cursor, mc); end
         tests++; if (full !== (mc == N)) begin failed++; $display("FAIL rand_full it=%0d got=%0b required=%0b", i, full, mc == N); end
         tests++; if (panel_string !== pub_bus()) begin failed++; $display("FAIL rand_string it=%0d got=%h required=%h", i, panel_string, pub_bus()); end
      end
   endtask

   initial begin
      test_reset();
      test_hello();
      test_hold();
      test_backspace();
      test_clear();
      test_full();
      test_same_edge();
      test_reset_mid_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
